// File: rtl/sec_filter_pkg.sv
// Shared constants, coefficient table and FSM encoding for the CIC compensation FIR.
package sec_filter_pkg;

    localparam int WIN      = 16;
    localparam int WC       = 18;
    localparam int NUM_COEF = 17;

    // Symmetric compensator taps in Q0.17 (sum|H| = 98920 < 2^17, sum H = 61440).
    localparam logic signed [WC-1:0] H [NUM_COEF] = '{
        -18'sd120,   18'sd310,  -18'sd650,  18'sd1180, -18'sd2100,  18'sd3600,
        -18'sd6500,  18'sd15000, 18'sd40000, 18'sd15000, -18'sd6500, 18'sd3600,
        -18'sd2100,  18'sd1180, -18'sd650,   18'sd310,  -18'sd120
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

endpackage

// File: rtl/sec_filter_coef_rom.sv
// Combinational tap-coefficient lookup addressed by the MAC tap counter.
module sec_filter_coef_rom
    import sec_filter_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0]        addr,
    output logic signed [WC-1:0] coef
);

    always_comb begin
        coef = '0;
        for (int k = 0; k < NUM_COEF; k++) begin
            if (addr == AW'(k)) coef = H[k];
        end
    end

endmodule

// File: rtl/sec_filter.sv
// Time-multiplexed 17-tap FIR: one multiplier, one accumulator, one tap per clock.
module sec_filter
    import sec_filter_pkg::*;
#(
    parameter int Win      = WIN,
    parameter int Wc       = WC,
    parameter int Num_coef = NUM_COEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic signed [Win-1:0] din,
    input  logic                  val_in,
    output logic signed [Win+2:0] dout,
    output logic                  val_out
);

    localparam int CW = $clog2(Num_coef);
    localparam logic [CW-1:0] LAST = CW'(Num_coef - 1);

    state_t                         state;
    logic [Num_coef-1:0][Win-1:0]   x;
    logic [CW-1:0]                  cnt;
    logic signed [Win+Wc-1:0]       acc;
    logic signed [Win+Wc-1:0]       prod;
    logic signed [Wc-1:0]           coef;

    sec_filter_coef_rom #(.AW(CW)) u_rom (
        .addr (cnt),
        .coef (coef)
    );

    assign prod = $signed(x[cnt]) * coef;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            x       <= '0;
            cnt     <= '0;
            acc     <= '0;
            dout    <= '0;
            val_out <= 1'b0;
        end else begin
            val_out <= 1'b0;
            case (state)
                // Samples arriving while busy are dropped without shifting the line.
                ST_IDLE: if (val_in) begin
                    x     <= {x[Num_coef-2:0], din};
                    acc   <= '0;
                    cnt   <= '0;
                    state <= ST_MAC;
                end
                ST_MAC: begin
                    acc <= acc + prod;
                    if (cnt == LAST) state <= ST_OUT;
                    else             cnt   <= cnt + 1'b1;
                end
                ST_OUT: begin
                    dout    <= acc[Win+Wc-1:Wc-3];
                    val_out <= 1'b1;
                    cnt     <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sec_filter.sv
// Scoreboard bench for sec_filter: driver pushes expected results, monitor pops on val_out.
module tb_sec_filter;

    localparam int GAP = 25;
    localparam int LAT = 18;

    typedef struct {
        logic [18:0] d;
        int          t;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] din = '0;
    logic               val_in = 1'b0;
    logic signed [18:0] dout;
    logic               val_out;

    sec_filter dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .val_in  (val_in),
        .dout    (dout),
        .val_out (val_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    exp_t sb[$];
    logic [18:0] last_dout = '0;

    int hb [17] = '{-120, 310, -650, 1180, -2100, 3600, -6500, 15000, 40000,
                    15000, -6500, 3600, -2100, 1180, -650, 310, -120};
    int xm [17];

    function automatic logic [18:0] model_out();
        longint s;
        logic [33:0] a;
        s = 0;
        for (int k = 0; k < 17; k++) s += longint'(hb[k]) * longint'(xm[k]);
        a = s[33:0];
        return a[33:15];
    endfunction

    function automatic void model_shift(input int d);
        for (int k = 16; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = d;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 17; k++) xm[k] = 0;
    endfunction

    // Monitor: sample #1 after the rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            n_chk++;
            if (val_out !== 1'b0 || dout !== 19'd0) begin
                n_err++;
                $display("FAIL reset_hold: val_out=%b dout=%0d, required 0/0", val_out, dout);
            end
            last_dout = '0;
        end else if (val_out) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_val_out: got pulse at cycle %0d, required none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (dout !== e.d) begin
                    n_err++;
                    $display("FAIL dout: got %0d, required %0d", $signed(dout), $signed(e.d));
                end
                n_chk++;
                if (cyc != e.t + LAT) begin
                    n_err++;
                    $display("FAIL latency: got %0d cycles, required %0d", cyc - e.t, LAT);
                end
            end
            last_dout = dout;
        end else begin
            n_chk++;
            if (dout !== last_dout) begin
                n_err++;
                $display("FAIL dout_stable: got %0d, required %0d", $signed(dout), $signed(last_dout));
            end
        end
    end

    task automatic send(input logic signed [15:0] d, input bit ovr, input logic [18:0] ev);
        exp_t e;
        model_shift(int'(d));
        e.d = ovr ? ev : model_out();
        @(negedge clk);
        din    = d;
        val_in = 1'b1;
        e.t    = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        val_in = 1'b0;
        repeat (GAP - 1) @(negedge clk);
    endtask

    initial begin
        model_clear();

        // Reset held with random activity on the inputs.
        repeat (20) begin
            @(negedge clk);
            din    = 16'($urandom);
            val_in = 1'($urandom);
        end
        @(negedge clk);
        val_in = 1'b0;
        rst    = 1'b1;

        // First output after reset: H[0]*din truncated.
        send(16'sh1234, 1'b0, '0);

        // Busy rejection: a second strobe 5 cycles later is dropped.
        begin
            exp_t e;
            model_shift(16'sh2000);
            e.d = model_out();
            @(negedge clk);
            din = 16'sh2000; val_in = 1'b1;
            e.t = cyc + 1;
            sb.push_back(e);
            @(negedge clk);
            val_in = 1'b0;
            repeat (4) @(negedge clk);
            din = 16'sh7000; val_in = 1'b1;
            @(negedge clk);
            val_in = 1'b0;
            repeat (GAP) @(negedge clk);
        end
        // Next output proves the line advanced only once.
        send(16'sh0100, 1'b0, '0);

        // Reset mid-sweep aborts with no val_out.
        @(negedge clk);
        din = 16'sh4000; val_in = 1'b1;
        @(negedge clk);
        val_in = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_clear();
        repeat (5) @(negedge clk);

        // Impulse: 0x4000 then zeros gives H[k]>>>1.
        send(16'sh4000, 1'b1, 19'(hb[0] >>> 1));
        for (int k = 1; k < 17; k++) send(16'sh0000, 1'b1, 19'(hb[k] >>> 1));
        send(16'sh0000, 1'b1, 19'd0);

        // DC full scale: settles to floor(32767*61440/2^15) = 61438.
        for (int i = 0; i < 20; i++) send(16'sh7FFF, (i >= 16), 19'd61438);

        // Regression with pseudo-random samples.
        for (int i = 0; i < 101; i++) send(16'($urandom), 1'b0, '0);

        // Drain: bounded wait for outstanding results.
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
